// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS EX-stage blocks.
//   - R-type funct codes for the multiply unit (MULTU / MFHI / MFLO)
//   - state encoding of the multiply sequencer FSM
package mips_pkg;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/multu_step.sv
// multu_step: one combinational shift-add step of the unsigned multiplier.
//   product_i [2W-1:0]  current {partial sum, remaining multiplier bits}
//   mcand_i   [W-1:0]   multiplicand
//   product_o [2W-1:0]  product after this step
module multu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] product_i,
    input  logic [WIDTH-1:0]   mcand_i,
    output logic [2*WIDTH-1:0] product_o
);

    logic [WIDTH:0] sum;

    // The carry out of the upper half is kept and shifted in as the new MSB,
    // so no bit of the exact product is ever lost.
    always_comb begin
        sum       = {1'b0, product_i[2*WIDTH-1:WIDTH]}
                  + (product_i[0] ? {1'b0, mcand_i} : '0);
        product_o = {sum, product_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/multu_sequencer.sv
// multu_sequencer: multi-cycle unsigned multiply unit (MULTU/MFHI/MFLO).
//   clk, rst          clock, async active-high reset
//   start, op_a, op_b MULTU issued from EX with its operands
//   mf_req, mf_sel    MFHI/MFLO in ID (mf_sel: 1 = HI, 0 = LO)
//   busy              multiply in progress
//   done              one-cycle pulse, HI/LO hold the new product
//   stall             freeze PC, IF/ID and ID/EX
//   mf_data           combinational HI/LO read
//   hi, lo            architectural HI/LO registers
module multu_sequencer
    import mips_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mul_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] product_step;
    logic               accept;
    logic               last_step;

    multu_step #(.WIDTH(WIDTH)) u_step (
        .product_i (product_q),
        .mcand_i   (mcand_q),
        .product_o (product_step)
    );

    // A start seen while RUN is a structural hazard: it is stalled, not taken.
    assign accept    = start && (state_q != RUN);
    assign last_step = (state_q == RUN) && (count_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. The MF in ID is younger than a MULTU accepted this cycle, so
    // it must wait for that product as well.
    always_comb begin
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
        stall = ((state_q == RUN) && (mf_req || start)) || (start && mf_req);
    end

    // Datapath
    always_comb begin
        count_d   = count_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (accept) begin
            product_d = {{WIDTH{1'b0}}, op_b};
            mcand_d   = op_a;
            count_d   = '0;
        end else if (state_q == RUN) begin
            product_d = product_step;
            count_d   = count_q + 1'b1;
            if (last_step) begin
                hi_d = product_step[2*WIDTH-1:WIDTH];
                lo_d = product_step[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            product_q <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            count_q   <= count_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mf_data = mf_sel ? hi_q : lo_q;

endmodule
